fifo_wr_arbiter: RTL and testbench

//   Round-robin write arbiter that shares the single write port of the 8-deep FIFO between two producers.

---
 rtl/fifo_wr_arbiter_if.sv | 27 ++
 rtl/fifo_wr_arbiter.sv | 139 +++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_wr_arbiter_if.sv
// Write-side bus between the two producers, the arbiter and the FIFO.
// The master modport is the arbiter's view; slave is the producer/FIFO side.
interface fifo_wr_arbiter_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  req0;
  logic [DATA_WIDTH-1:0] data0;
  logic                  req1;
  logic [DATA_WIDTH-1:0] data1;
  logic                  fifo_full;
  logic                  fifo_wr_err;
  logic                  gnt0;
  logic                  gnt1;
  logic                  wr_en;
  logic [DATA_WIDTH-1:0] din;
  logic [7:0]            err_cnt;

  modport master (
    input  req0, data0, req1, data1, fifo_full, fifo_wr_err,
    output gnt0, gnt1, wr_en, din, err_cnt
  );

  modport slave (
    output req0, data0, req1, data1, fifo_full, fifo_wr_err,
    input  gnt0, gnt1, wr_en, din, err_cnt
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter sharing one FIFO write port between two producers,
// with bursts capped at MAX_BURST words while the other side waits.
module fifo_wr_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int MAX_BURST  = 4
) (
  input  logic               clk,
  input  logic               reset,
  fifo_wr_arbiter_if.master  bus
);

  localparam int CW = $clog2(MAX_BURST) + 1;
  localparam logic [CW-1:0] BURST_LAST = CW'(MAX_BURST - 1);
  localparam logic [CW-1:0] BURST_ONE  = CW'(1);
  localparam logic [CW-1:0] BURST_ZERO = CW'(0);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SERVE0 = 2'd1,
    SERVE1 = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   burst_cnt_q, burst_cnt_d;
  logic            last_grant_q, last_grant_d;
  logic [7:0]      err_cnt_q, err_cnt_d;
  logic            gnt0_s, gnt1_s;

  // State and counter registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      burst_cnt_q  <= BURST_ZERO;
      last_grant_q <= 1'b1;
      err_cnt_q    <= 8'd0;
    end else begin
      state_q      <= state_d;
      burst_cnt_q  <= burst_cnt_d;
      last_grant_q <= last_grant_d;
      err_cnt_q    <= err_cnt_d;
    end
  end

  // Next-state, burst counter and round-robin pointer
  always_comb begin
    state_d      = state_q;
    burst_cnt_d  = burst_cnt_q;
    last_grant_d = last_grant_q;
    case (state_q)
      IDLE: begin
        burst_cnt_d = BURST_ZERO;
        if (bus.req0 && bus.req1) begin
          state_d = last_grant_q ? SERVE0 : SERVE1;
        end else if (bus.req0) begin
          state_d = SERVE0;
        end else if (bus.req1) begin
          state_d = SERVE1;
        end else begin
          state_d = IDLE;
        end
      end
      SERVE0: begin
        if (!bus.req0) begin
          state_d      = bus.req1 ? SERVE1 : IDLE;
          burst_cnt_d  = BURST_ZERO;
          last_grant_d = 1'b0;
        end else if (gnt0_s) begin
          if (burst_cnt_q == BURST_LAST) begin
            // Cap reached: hand over only if the other side is waiting
            burst_cnt_d = BURST_ZERO;
            if (bus.req1) begin
              state_d      = SERVE1;
              last_grant_d = 1'b0;
            end else begin
              state_d = SERVE0;
            end
          end else begin
            burst_cnt_d = burst_cnt_q + BURST_ONE;
          end
        end else begin
          burst_cnt_d = burst_cnt_q;
        end
      end
      SERVE1: begin
        if (!bus.req1) begin
          state_d      = bus.req0 ? SERVE0 : IDLE;
          burst_cnt_d  = BURST_ZERO;
          last_grant_d = 1'b1;
        end else if (gnt1_s) begin
          if (burst_cnt_q == BURST_LAST) begin
            burst_cnt_d = BURST_ZERO;
            if (bus.req0) begin
              state_d      = SERVE0;
              last_grant_d = 1'b1;
            end else begin
              state_d = SERVE1;
            end
          end else begin
            burst_cnt_d = burst_cnt_q + BURST_ONE;
          end
        end else begin
          burst_cnt_d = burst_cnt_q;
        end
      end
      default: begin
        state_d      = IDLE;
        burst_cnt_d  = BURST_ZERO;
        last_grant_d = 1'b1;
      end
    endcase
  end

  // Saturating write-error counter, independent of the FSM
  always_comb begin
    if (bus.fifo_wr_err && (err_cnt_q != 8'hFF)) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end else begin
      err_cnt_d = err_cnt_q;
    end
  end

  // Grants and FIFO write port; a full FIFO suppresses the grant and the producer keeps its word
  always_comb begin
    gnt0_s      = (state_q == SERVE0) && bus.req0 && !bus.fifo_full;
    gnt1_s      = (state_q == SERVE1) && bus.req1 && !bus.fifo_full;
    bus.gnt0    = gnt0_s;
    bus.gnt1    = gnt1_s;
    bus.wr_en   = gnt0_s || gnt1_s;
    bus.err_cnt = err_cnt_q;
    if (gnt0_s) begin
      bus.din = bus.data0;
    end else if (gnt1_s) begin
      bus.din = bus.data1;
    end else begin
      bus.din = {DATA_WIDTH{1'b0}};
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: one task per scenario, inline checks,
// inputs driven 1ns after the rising edge and outputs sampled 1ns later.
module tb_fifo_wr_arbiter;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  fifo_wr_arbiter_if #(.DATA_WIDTH(32)) bus ();

  fifo_wr_arbiter #(.DATA_WIDTH(32), .MAX_BURST(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs;
    bus.req0        = 1'b0;
    bus.req1        = 1'b0;
    bus.data0       = 32'd0;
    bus.data1       = 32'd0;
    bus.fifo_full   = 1'b0;
    bus.fifo_wr_err = 1'b0;
  endtask

  task automatic do_reset;
    clear_inputs();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset;
    do_reset();
    step();
    bus.req0 = 1'b1; bus.req1 = 1'b1;
    bus.data0 = 32'h100; bus.data1 = 32'h200;
    bus.fifo_wr_err = 1'b1;
    step();
    #1;
    n_checks++;
    if (bus.gnt0 !== 1'b1) begin n_fail++; $display("FAIL rst_pre_gnt0: got %b expected 1", bus.gnt0); end
    n_checks++;
    if (bus.err_cnt !== 8'd1) begin n_fail++; $display("FAIL rst_pre_err: got %0d expected 1", bus.err_cnt); end
    bus.fifo_wr_err = 1'b0;
    reset = 1'b1;
    #1;
    n_checks++;
    if ({bus.gnt0, bus.gnt1, bus.wr_en} !== 3'b000) begin
      n_fail++; $display("FAIL rst_async_gnt: got %b expected 000", {bus.gnt0, bus.gnt1, bus.wr_en});
    end
    n_checks++;
    if (bus.din !== 32'd0) begin n_fail++; $display("FAIL rst_async_din: got %h expected 0", bus.din); end
    n_checks++;
    if (bus.err_cnt !== 8'd0) begin n_fail++; $display("FAIL rst_async_err: got %0d expected 0", bus.err_cnt); end
    step();
    reset = 1'b0;
    #1;
    n_checks++;
    if ({bus.gnt0, bus.gnt1, bus.wr_en} !== 3'b000) begin
      n_fail++; $display("FAIL rst_release_gnt: got %b expected 000", {bus.gnt0, bus.gnt1, bus.wr_en});
    end
    n_checks++;
    if (2'(dut.state_q) !== 2'd0) begin n_fail++; $display("FAIL rst_release_idle: got %0d expected 0", dut.state_q); end
    step();
    #1;
    n_checks++;
    if (bus.gnt0 !== 1'b1 || bus.din !== 32'h100) begin
      n_fail++; $display("FAIL rst_first_gnt: got gnt0=%b din=%h expected gnt0=1 din=100", bus.gnt0, bus.din);
    end
    clear_inputs();
  endtask

  task automatic test_single_producer;
    logic [31:0] vals [3];
    vals = '{32'h11, 32'h22, 32'h33};
    do_reset();
    step();
    bus.req0 = 1'b1; bus.data0 = vals[0];
    #1;
    n_checks++;
    if (bus.wr_en !== 1'b0) begin n_fail++; $display("FAIL single_latency: got wr_en=%b expected 0", bus.wr_en); end
    for (int i = 0; i < 3; i++) begin
      step();
      bus.data0 = vals[i];
      #1;
      n_checks++;
      if (bus.gnt0 !== 1'b1 || bus.wr_en !== 1'b1 || bus.din !== vals[i]) begin
        n_fail++;
        $display("FAIL single_word%0d: got gnt0=%b wr_en=%b din=%h expected 1 1 %h", i, bus.gnt0, bus.wr_en, bus.din, vals[i]);
      end
    end
    step();
    bus.req0 = 1'b0;
    #1;
    n_checks++;
    if (bus.wr_en !== 1'b0) begin n_fail++; $display("FAIL single_stop: got wr_en=%b expected 0", bus.wr_en); end
    step();
    #1;
    n_checks++;
    if (2'(dut.state_q) !== 2'd0 || dut.last_grant_q !== 1'b0) begin
      n_fail++; $display("FAIL single_idle: got state=%0d last=%b expected 0 0", dut.state_q, dut.last_grant_q);
    end
    clear_inputs();
  endtask

  task automatic test_round_robin;
    int n0, n1;
    logic exp0;
    logic [31:0] exp_din;
    n0 = 0; n1 = 0;
    do_reset();
    step();
    bus.req0 = 1'b1; bus.req1 = 1'b1;
    bus.data0 = 32'hA000_0000; bus.data1 = 32'hB000_0000;
    #1;
    n_checks++;
    if (bus.wr_en !== 1'b0) begin n_fail++; $display("FAIL rr_idle: got wr_en=%b expected 0", bus.wr_en); end
    for (int i = 0; i < 12; i++) begin
      step();
      bus.data0 = 32'hA000_0000 + 32'(n0);
      bus.data1 = 32'hB000_0000 + 32'(n1);
      #1;
      exp0    = ((i / 4) % 2) == 0;
      exp_din = exp0 ? (32'hA000_0000 + 32'(n0)) : (32'hB000_0000 + 32'(n1));
      n_checks++;
      if (bus.gnt0 !== exp0 || bus.gnt1 !== !exp0 || bus.wr_en !== 1'b1 || bus.din !== exp_din) begin
        n_fail++;
        $display("FAIL rr_cycle%0d: got g0=%b g1=%b we=%b din=%h expected g0=%b g1=%b we=1 din=%h",
                 i, bus.gnt0, bus.gnt1, bus.wr_en, bus.din, exp0, !exp0, exp_din);
      end
      if (exp0) n0++; else n1++;
    end
    clear_inputs();
  endtask

  task automatic test_fifo_full;
    logic [6:0] exp_g0, exp_g1;
    int n0;
    exp_g0 = 7'b0110011;  // bit c-1 = cycle c
    exp_g1 = 7'b1000000;
    n0 = 0;
    do_reset();
    step();
    bus.req0 = 1'b1; bus.req1 = 1'b1;
    bus.data0 = 32'hC000_0000; bus.data1 = 32'hD000_0000;
    for (int c = 1; c <= 7; c++) begin
      step();
      bus.fifo_full = (c == 3) || (c == 4);
      bus.data0     = 32'hC000_0000 + 32'(n0);
      #1;
      n_checks++;
      if (bus.gnt0 !== exp_g0[c-1] || bus.gnt1 !== exp_g1[c-1] || bus.wr_en !== (exp_g0[c-1] | exp_g1[c-1])) begin
        n_fail++;
        $display("FAIL full_cycle%0d: got g0=%b g1=%b we=%b expected g0=%b g1=%b",
                 c, bus.gnt0, bus.gnt1, bus.wr_en, exp_g0[c-1], exp_g1[c-1]);
      end
      if (c == 3 || c == 4) begin
        n_checks++;
        if (dut.burst_cnt_q !== 3'd2) begin
          n_fail++; $display("FAIL full_hold%0d: got burst_cnt=%0d expected 2", c, dut.burst_cnt_q);
        end
      end
      if (exp_g0[c-1]) begin
        n_checks++;
        if (bus.din !== 32'hC000_0000 + 32'(n0)) begin
          n_fail++; $display("FAIL full_din%0d: got %h expected %h", c, bus.din, 32'hC000_0000 + 32'(n0));
        end
        n0++;
      end
    end
    clear_inputs();
  endtask

  task automatic test_err_saturation;
    do_reset();
    step();
    bus.fifo_wr_err = 1'b1;
    #1;
    n_checks++;
    if (bus.err_cnt !== 8'd0) begin n_fail++; $display("FAIL err_start: got %0d expected 0", bus.err_cnt); end
    for (int i = 1; i <= 300; i++) begin
      step();
      #1;
      if (i == 100 || i == 254) begin
        n_checks++;
        if (bus.err_cnt !== 8'(i)) begin n_fail++; $display("FAIL err_count%0d: got %0d expected %0d", i, bus.err_cnt, i); end
      end
      if (i == 255 || i == 300) begin
        n_checks++;
        if (bus.err_cnt !== 8'd255) begin n_fail++; $display("FAIL err_sat%0d: got %0d expected 255", i, bus.err_cnt); end
      end
    end
    bus.fifo_wr_err = 1'b0;
    step();
    step();
    #1;
    n_checks++;
    if (bus.err_cnt !== 8'd255) begin n_fail++; $display("FAIL err_hold: got %0d expected 255", bus.err_cnt); end
    clear_inputs();
  endtask

  task automatic test_handover_on_drop;
    do_reset();
    step();
    bus.req0 = 1'b1; bus.data0 = 32'h55;
    step();
    #1;
    n_checks++;
    if (bus.gnt0 !== 1'b1 || bus.din !== 32'h55) begin
      n_fail++; $display("FAIL drop_gnt0: got gnt0=%b din=%h expected 1 55", bus.gnt0, bus.din);
    end
    step();
    bus.req0 = 1'b0; bus.req1 = 1'b1; bus.data1 = 32'h66;
    #1;
    n_checks++;
    if (bus.wr_en !== 1'b0) begin n_fail++; $display("FAIL drop_gap: got wr_en=%b expected 0", bus.wr_en); end
    step();
    #1;
    n_checks++;
    if (bus.gnt1 !== 1'b1 || bus.din !== 32'h66) begin
      n_fail++; $display("FAIL drop_gnt1: got gnt1=%b din=%h expected 1 66", bus.gnt1, bus.din);
    end
    n_checks++;
    if (dut.last_grant_q !== 1'b0) begin n_fail++; $display("FAIL drop_last: got %b expected 0", dut.last_grant_q); end
    clear_inputs();
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b1;
    clear_inputs();
    test_reset();
    test_single_producer();
    test_round_robin();
    test_fifo_full();
    test_err_saturation();
    test_handover_on_drop();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
